uart_bus: RTL

Memory-mapped UART peripheral on the 68000 bus. It connects the CPU to the FTDI serial pins: `txd` drives `ftdi_rxd` and `rxd` is fed from `ftdi_txd`. Both directions are FIFO-buffered. It sits beside the ROM, RAM and LED decodes, selected by its own chip select, and its `dout` is one more input to the CPU read-data mux.

---
 rtl/uart_bus.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_bus.sv
// uart_bus: 68000-bus UART with TX/RX FIFOs.
// DATA/STATUS registers, 8N1 framing, fixed baud divisor.
module uart_bus #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        rw,
  input  logic        addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        irq,
  input  logic        rxd,
  output logic        txd
);
  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_e;

  logic          cs_s_q, cs_s_d;
  logic          cs_p_q, cs_p_d;
  logic          stb, rd_data, wr_data, rd_stat;
  logic [15:0]   dout_q, dout_d;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;

  logic [AW:0]   tx_wp_q, tx_wp_d;
  logic [AW:0]   tx_rp_q, tx_rp_d;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic          tx_empty, tx_full;
  logic          tx_push, tx_pop, tx_idle;

  logic [AW:0]   rx_wp_q, rx_wp_d;
  logic [AW:0]   rx_rp_q, rx_rp_d;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic          rx_empty, rx_full;
  logic          rx_push, rx_pop;

  st_e           tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;
  logic          tx_tick;

  logic          rx_s1_q, rx_s2_q;
  st_e           rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_tick, rx_half;
  logic          rx_done, rx_good, rx_bad, ovr_set;

  logic          din_unused;

  assign din_unused = ^din[15:8];

  // cs is sampled first, so the action lands one edge after it is seen
  assign stb     = cs_s_q & ~cs_p_q;
  assign rd_data = stb & rw & ~addr;
  assign wr_data = stb & ~rw & ~addr;
  assign rd_stat = stb & rw & addr;

  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q ^ tx_rp_q) == {1'b1, {AW{1'b0}}};
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q ^ rx_rp_q) == {1'b1, {AW{1'b0}}};
  assign tx_idle  = tx_empty & (tx_st_q == S_IDLE);

  assign tx_push  = wr_data & (~tx_full | tx_pop);
  assign rx_pop   = rd_data & ~rx_empty;
  assign rx_push  = rx_good & (~rx_full | rx_pop);
  assign ovr_set  = rx_good & rx_full & ~rx_pop;

  assign tx_tick  = tx_cnt_q == CW'(DIV - 1);
  assign rx_tick  = rx_cnt_q == CW'(DIV - 1);
  assign rx_half  = rx_cnt_q == CW'(HALF - 2);

  assign dout = dout_q;
  assign irq  = ~rx_empty;
  assign txd  = txd_q;

  always_comb begin
    cs_s_d  = cs;
    cs_p_d  = cs_s_q;
    tx_wp_d = tx_wp_q + (AW + 1)'(tx_push);
    tx_rp_d = tx_rp_q + (AW + 1)'(tx_pop);
    rx_wp_d = rx_wp_q + (AW + 1)'(rx_push);
    rx_rp_d = rx_rp_q + (AW + 1)'(rx_pop);
    ovr_d   = (ovr_q & ~rd_stat) | ovr_set;
    fe_d    = (fe_q & ~rd_stat) | rx_bad;
    dout_d  = dout_q;
    unique case (1'b1)
      rd_data: dout_d = rx_empty ? 16'h0000
                      : {8'h00, rx_mem[rx_rp_q[AW-1:0]]};
      rd_stat: dout_d = {11'b0, fe_q, ovr_q, tx_idle,
                         ~tx_full, ~rx_empty};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= din[7:0];
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s_q  <= 1'b0;
      cs_p_q  <= 1'b0;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      cs_s_q  <= cs_s_d;
      cs_p_q  <= cs_p_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
    end
  end

  // a pop at the end of STOP chains straight into the next START
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    if (tx_pop) tx_sh_d = tx_mem[tx_rp_q[AW-1:0]];
    unique case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_pop) tx_st_d = S_START;
      end
      S_START: begin
        if (tx_tick) begin
          tx_st_d  = S_DATA;
          tx_bit_d = '0;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_tick) tx_st_d = tx_pop ? S_START : S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    txd_d  = 1'b1;
    unique case (tx_st_q)
      S_IDLE:  tx_pop = ~tx_empty;
      S_START: txd_d  = 1'b0;
      S_DATA:  txd_d  = tx_sh_q[0];
      S_STOP:  tx_pop = tx_tick & ~tx_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_s1_q  <= rxd;
      rx_s2_q  <= rx_s1_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    unique case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_st_d = S_START;
      end
      S_START: begin
        if (rx_half) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_cnt_d = '0;
          rx_st_d  = S_IDLE;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_st_q == S_STOP) & rx_tick;
    rx_good = rx_done & rx_s2_q;
    rx_bad  = rx_done & ~rx_s2_q;
  end

endmodule
